// File: rtl/light_pwm_driver.sv
// Eight-channel 4-bit PWM LED driver fed from a 32-bit lights word; levels latch only at frame boundaries.
// Optional per-frame fade toward the latched target is built when LIGHT_PWM_FADE_EN is defined.
module light_pwm_driver #(
  parameter int PRESCALE_DIV = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] level_in,
  input  logic        enable,
  output logic [7:0]  leds_out,
  output logic        frame_tick,
  output logic        busy
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE_DIV - 1);
  localparam logic [3:0]    STEP_LAST = 4'd14;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [3:0]    pwm_count;
  logic [3:0]    target [8];
  logic [3:0]    active [8];
  logic [7:0]    lit;
  logic          frame_start;

  // Entering RUN is itself a frame start, so levels are never stale on the first frame.
  assign frame_start = enable &&
                       ((state == IDLE) || (prescaler == PRE_LAST && pwm_count == STEP_LAST));
  assign busy = (state == RUN);

`ifdef LIGHT_PWM_FADE_EN
  function automatic logic [3:0] fade_step(input logic [3:0] cur, input logic [3:0] tgt);
    if (cur < tgt)      return cur + 4'd1;
    else if (cur > tgt) return cur - 4'd1;
    else                return cur;
  endfunction
`else
  always_comb begin
    for (int i = 0; i < 8; i++) active[i] = target[i];
  end
`endif

  // Level 15 stays lit for the whole frame because pwm_count tops out at 14.
  // NOTE: every bit of lit is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) lit[i] = (pwm_count < active[i]);
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      prescaler  <= '0;
      pwm_count  <= '0;
      leds_out   <= '0;
      frame_tick <= 1'b0;
      // NOTE: the level arrays are only 64 flops, so they are reset like any other register.
      for (int i = 0; i < 8; i++) begin
        target[i] <= '0;
`ifdef LIGHT_PWM_FADE_EN
        active[i] <= '0;
`endif
      end
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        for (int i = 0; i < 8; i++) begin
          target[i] <= level_in[4*i +: 4];
`ifdef LIGHT_PWM_FADE_EN
          active[i] <= fade_step(active[i], target[i]);
`endif
        end
      end

      case (state)
        IDLE: begin
          prescaler <= '0;
          pwm_count <= '0;
          leds_out  <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state     <= IDLE;
            prescaler <= '0;
            pwm_count <= '0;
            leds_out  <= '0;
          end else begin
            leds_out <= lit;
            if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              pwm_count <= (pwm_count == STEP_LAST) ? 4'd0 : pwm_count + 4'd1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
